// File: rtl/delay_line_sampler_if.sv
// Handshake and delay-line signals of delay_line_sampler.
// The master side issues start/taps/result_ready; the slave side is the sampler.
interface delay_line_sampler_if #(
  parameter int N_TAPS = 8,
  parameter int CW     = 4
);
  logic              start;
  logic              launch;
  logic [N_TAPS-1:0] taps;
  logic              busy;
  logic [CW-1:0]     result;
  logic              result_valid;
  logic              result_ready;
  logic              bubble_err;

  modport master (
    output start, taps, result_ready,
    input  launch, busy, result, result_valid, bubble_err
  );

  modport slave (
    input  start, taps, result_ready,
    output launch, busy, result, result_valid, bubble_err
  );
endinterface

// File: rtl/delay_line_sampler.sv
// Launches an edge into a tapped delay line, captures the thermometer code and
// averages the leading-ones count over 2^AVG_LOG2 samples.
module delay_line_sampler #(
  parameter int N_TAPS   = 8,
  parameter int AVG_LOG2 = 2
) (
  input logic                  clk,
  input logic                  rst,
  delay_line_sampler_if.slave  bus
);
  localparam int CW  = $clog2(N_TAPS + 1);
  localparam int AW  = CW + AVG_LOG2;
  localparam int SCW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [SCW-1:0] LAST_SAMPLE = SCW'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    LAUNCH  = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_launch;
  logic              r_busy;
  logic              r_valid;
  logic              r_bubble;
  logic [CW-1:0]     r_result;
  logic [AW-1:0]     r_acc;
  logic [SCW-1:0]    r_cnt;
  logic [N_TAPS-1:0] r_tap_q;

  logic [CW-1:0]     w_count;
  logic              w_run;
  logic              w_bubble;
  logic [AW-1:0]     w_acc_sum;

  // Leading-ones run from bit 0; stops at the first zero.
  always_comb begin
    w_count = '0;
    w_run   = 1'b1;
    for (int i = 0; i < N_TAPS; i++) begin
      if (w_run && r_tap_q[i]) begin
        w_count = w_count + CW'(1);
      end else begin
        w_run = 1'b0;
      end
    end
  end

  // A legal code 0..01..1 plus one has no bit in common with itself.
  assign w_bubble  = |(r_tap_q & (r_tap_q + N_TAPS'(1)));
  assign w_acc_sum = r_acc + AW'(w_count);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_launch <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_bubble <= 1'b0;
      r_result <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_tap_q  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state  <= ARM;
            r_busy   <= 1'b1;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_bubble <= 1'b0;
          end
        end
        ARM: begin
          r_state  <= LAUNCH;
          r_launch <= 1'b1;
        end
        LAUNCH: begin
          r_state  <= CAPTURE;
          r_launch <= 1'b0;
          r_tap_q  <= bus.taps;
        end
        CAPTURE: begin
          r_acc <= w_acc_sum;
          if (w_bubble) begin
            r_bubble <= 1'b1;
          end
          if (r_cnt == LAST_SAMPLE) begin
            r_state  <= DONE;
            r_result <= w_acc_sum[AW-1:AVG_LOG2];
            r_valid  <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + SCW'(1);
            r_state <= ARM;
          end
        end
        DONE: begin
          if (bus.result_ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.launch       = r_launch;
  assign bus.busy         = r_busy;
  assign bus.result       = r_result;
  assign bus.result_valid = r_valid;
  assign bus.bubble_err   = r_bubble;
endmodule

// File: tb/tb_delay_line_sampler.sv
// Scoreboard bench for delay_line_sampler: driver pushes expected results,
// an independent monitor pops and compares on each result handshake.
module tb_delay_line_sampler;
  localparam int N  = 8;
  localparam int A  = 2;
  localparam int CW = 4;
  localparam int NS = 1 << A;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  delay_line_sampler_if #(.N_TAPS(N), .CW(CW)) bus ();

  delay_line_sampler #(.N_TAPS(N), .AVG_LOG2(A)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [CW-1:0] res;
    logic          bub;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: length of the run of ones from bit 0.
  function automatic int tcount(input logic [N-1:0] t);
    int c = 0;
    while (c < N && t[c] == 1'b1) c++;
    return c;
  endfunction

  task automatic run_meas(input logic [N-1:0] s[NS], input int rdly);
    int   sum = 0;
    logic bub = 1'b0;
    int   c, cyc, idx;
    exp_t e;
    for (int i = 0; i < NS; i++) begin
      c = tcount(s[i]);
      sum += c;
      if (int'(s[i]) != (1 << c) - 1) bub = 1'b1;
    end
    e.res = CW'(sum / NS);
    e.bub = bub;
    q.push_back(e);

    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 1);
    chk("bubble_cleared_on_start", 32'(bus.bubble_err), 0);
    cyc = 0;
    idx = 0;
    while (!bus.result_valid && cyc < 100) begin
      if (bus.launch) begin
        chk("launch_cycle", cyc, 1 + 3 * idx);
        bus.taps = (idx < NS) ? s[idx] : '0;
        idx++;
      end else begin
        bus.taps = N'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, 3 * NS);
    chk("launch_pulses", idx, NS);

    for (int k = 0; k < rdly; k++) begin
      bus.start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("valid_held", 32'(bus.result_valid), 1);
    bus.result_ready = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
    bus.start = 1'b0;
    chk("idle_busy", 32'(bus.busy), 0);
    chk("valid_cleared", 32'(bus.result_valid), 0);
    chk("result_held_idle", 32'(bus.result), 32'(e.res));
    chk("bubble_held_idle", 32'(bus.bubble_err), 32'(e.bub));
    // Stray ready while idle must not matter.
    bus.result_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    bus.result_ready = 1'b0;
    chk("idle_after_stray_ready", 32'(bus.busy), 0);
  endtask

  // Monitor: samples 1 time unit after each falling edge, when inputs are settled.
  initial begin
    logic [CW-1:0] last;
    bit            have;
    exp_t          e;
    have = 1'b0;
    last = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        have = 1'b0;
      end else if (bus.result_valid) begin
        if (have) chk("result_stable", 32'(bus.result), 32'(last));
        last = bus.result;
        have = 1'b1;
        if (bus.result_ready) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result actual=%0d required=none", bus.result);
          end else begin
            e = q.pop_front();
            chk("sb_result", 32'(bus.result), 32'(e.res));
            chk("sb_bubble", 32'(bus.bubble_err), 32'(e.bub));
          end
          have = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [N-1:0] s[NS];
    int bad, k, c;
    bus.start = 1'b0;
    bus.taps = '0;
    bus.result_ready = 1'b0;

    #1 rst = 1'b1;
    #2;
    chk("rst_launch", 32'(bus.launch), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_result", 32'(bus.result), 0);
    chk("rst_valid", 32'(bus.result_valid), 0);
    chk("rst_bubble", 32'(bus.bubble_err), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.launch !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    chk("idle_quiet_20", bad, 0);

    s = '{8'h07, 8'h07, 8'h07, 8'h07};  run_meas(s, 0);
    s = '{8'h01, 8'h03, 8'h07, 8'h0F};  run_meas(s, 5);
    s = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};  run_meas(s, 1);
    s = '{8'h00, 8'h00, 8'h00, 8'h00};  run_meas(s, 2);
    s = '{8'h05, 8'h05, 8'h05, 8'h05};  run_meas(s, 3);
    s = '{8'h03, 8'h03, 8'h03, 8'h03};  run_meas(s, 0);

    // Reset in the middle of LAUNCH.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    while (!bus.launch && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("abort_reached_launch", 32'(bus.launch), 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_launch", 32'(bus.launch), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_valid", 32'(bus.result_valid), 0);
    chk("abort_result", 32'(bus.result), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    chk("abort_no_valid", bad, 0);
    s = '{8'h1F, 8'h0F, 8'h3F, 8'h07};  run_meas(s, 1);

    for (int m = 0; m < 40; m++) begin
      for (int i = 0; i < NS; i++) begin
        if ($urandom_range(0, 3) != 0) begin
          c = $urandom_range(0, N);
          s[i] = N'((1 << c) - 1);
        end else begin
          s[i] = N'($urandom);
        end
      end
      run_meas(s, $urandom_range(0, 5));
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
